// File: rtl/lcd_driver.sv
// lcd_driver: HD44780-style write controller with power-up init, one-deep request slot and overrun flag.
module lcd_driver #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_overrun
);
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

    localparam int TMAX = max2(max2(max2(T_PWRUP, T_SETUP), max2(T_EN, T_HOLD)), max2(T_EXEC, T_LONG));
    localparam int CW = $clog2(TMAX) + 1;

    localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(T_LONG - 1);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    function automatic logic [7:0] init_cmd(input logic [2:0] i);
        return i == 3'd3 ? 8'h0C : i == 3'd4 ? 8'h01 : i == 3'd5 ? 8'h06 : 8'h38;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d, pdata_q, pdata_d;
    logic          rs_q, rs_d, prs_q, prs_d;
    logic          pend_q, pend_d, prev_q, on_q, done_q, done_d, ovr_q, ovr_d;
    logic          req, direct, drain, zero, long_wait, unused_bits;

    assign unused_bits = ^{i_lcd_word[30:11], i_lcd_word[9]};
    assign req         = i_lcd_word[10] ^ prev_q;
    assign zero        = cnt_q == '0;
    assign long_wait   = !rs_q && data_q[7:1] == 7'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = zero ? cnt_q : cnt_q - CW'(1);
        idx_d   = idx_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = done_q;
        direct  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            S_PWRUP: if (zero) begin
                state_d = S_SETUP;
                cnt_d   = L_SETUP;
                rs_d    = 1'b0;
                data_d  = init_cmd(3'd0);
                idx_d   = 3'd1;
            end
            S_IDLE: if (pend_q || req) begin
                state_d = S_SETUP;
                cnt_d   = L_SETUP;
                rs_d    = pend_q ? prs_q : i_lcd_word[8];
                data_d  = pend_q ? pdata_q : i_lcd_word[7:0];
                drain   = pend_q;
                direct  = !pend_q;
            end
            S_SETUP: if (zero) begin
                state_d = S_PULSE;
                cnt_d   = L_EN;
            end
            S_PULSE: if (zero) begin
                state_d = S_HOLD;
                cnt_d   = L_HOLD;
            end
            S_HOLD: if (zero) begin
                state_d = S_WAIT;
                cnt_d   = long_wait ? L_LONG : L_EXEC;
            end
            S_WAIT: if (zero) begin
                if (idx_q < 3'd6) begin
                    state_d = S_SETUP;
                    cnt_d   = L_SETUP;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(idx_q);
                    idx_d   = idx_q + 3'd1;
                end else if (pend_q) begin
                    state_d = S_SETUP;
                    cnt_d   = L_SETUP;
                    rs_d    = prs_q;
                    data_d  = pdata_q;
                    drain   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_PWRUP;
        endcase
    end

    // A draining slot can accept a new request on the same edge without overrun.
    always_comb begin
        pend_d  = drain ? 1'b0 : pend_q;
        prs_d   = prs_q;
        pdata_d = pdata_q;
        ovr_d   = ovr_q;
        if (req && !direct) begin
            if (!pend_q || drain) begin
                pend_d  = 1'b1;
                prs_d   = i_lcd_word[8];
                pdata_d = i_lcd_word[7:0];
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_PWRUP;
            cnt_q   <= L_PWRUP;
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'd0;
            prs_q   <= 1'b0;
            pdata_q <= 8'd0;
            pend_q  <= 1'b0;
            prev_q  <= 1'b0;
            on_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            prs_q   <= prs_d;
            pdata_q <= pdata_d;
            pend_q  <= pend_d;
            prev_q  <= i_lcd_word[10];
            on_q    <= i_lcd_word[31];
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_lcd_data  = data_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = state_q == S_PULSE;
    assign o_lcd_on    = on_q;
    assign o_busy      = state_q != S_IDLE;
    assign o_init_done = done_q;
    assign o_overrun   = ovr_q;
endmodule
